// File: rtl/effects_pkg.sv
// Shared constants and types for the audio effects chain.
package effects_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DLY_ADDR_W = 10;
  localparam int LFO_W      = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/flanger_delay_line_delay_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
module delay_ram
  import effects_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int ADDR_WIDTH = DLY_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdData_q;

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rdData_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/flanger_delay_line.sv
// Flanger/chorus core: circular delay buffer with an LFO-modulated tap mixed 50/50 with the dry sample.
module flanger_delay_line
  import effects_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int ADDR_WIDTH = DLY_ADDR_W,
  parameter int MOD_WIDTH  = LFO_W,
  parameter int BASE_DELAY = 64
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic        [MOD_WIDTH-1:0]  mod_value,
  input  logic                         enable,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_sample
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int MAX_D = DEPTH - 2;

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic                  s1Valid_q, s1Valid_d;
  logic                  s1WetOk_q, s1WetOk_d;
  logic                  s1Enable_q, s1Enable_d;
  logic [DATA_WIDTH-1:0] s1Dry_q, s1Dry_d;
  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] outSample_q, outSample_d;

  logic [31:0]           dSum;
  logic [ADDR_WIDTH-1:0] dClamp;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic                  wetOk;
  logic [DATA_WIDTH-1:0] ramData;
  logic [DATA_WIDTH-1:0] wet;
  logic [DATA_WIDTH:0]   mixSum;

  assign dSum   = 32'(BASE_DELAY) + 32'(mod_value);
  assign dClamp = (dSum > 32'(MAX_D)) ? ADDR_WIDTH'(MAX_D) : dSum[ADDR_WIDTH-1:0];
  assign rdAddr = wrPtr_q - dClamp;
  assign wetOk  = (fill_q >= dClamp);

  delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .CLK       (CLK),
    .wr_en_i   (in_valid),
    .wr_addr_i (wrPtr_q),
    .wr_data_i (in_sample),
    .rd_addr_i (rdAddr),
    .rd_data_o (ramData)
  );

  // Gating on wetOk keeps stale RAM contents (from before reset) out of the mix.
  assign wet    = s1WetOk_q ? ramData : '0;
  assign mixSum = {wet[DATA_WIDTH-1], wet} + {s1Dry_q[DATA_WIDTH-1], s1Dry_q};

  always_comb begin
    wrPtr_d     = wrPtr_q;
    fill_d      = fill_q;
    s1Valid_d   = in_valid;
    s1WetOk_d   = s1WetOk_q;
    s1Enable_d  = s1Enable_q;
    s1Dry_d     = s1Dry_q;
    outValid_d  = s1Valid_q;
    outSample_d = outSample_q;

    if (in_valid) begin
      wrPtr_d    = wrPtr_q + 1'b1;
      fill_d     = (fill_q == '1) ? fill_q : fill_q + 1'b1;
      s1WetOk_d  = wetOk;
      s1Enable_d = enable;
      s1Dry_d    = in_sample;
    end

    // Dropping the sum LSB is the floor of an arithmetic shift by one.
    if (s1Valid_q) begin
      outSample_d = s1Enable_q ? mixSum[DATA_WIDTH:1] : s1Dry_q;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wrPtr_q     <= '0;
      fill_q      <= '0;
      s1Valid_q   <= 1'b0;
      s1WetOk_q   <= 1'b0;
      s1Enable_q  <= 1'b0;
      s1Dry_q     <= '0;
      outValid_q  <= 1'b0;
      outSample_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      fill_q      <= fill_d;
      s1Valid_q   <= s1Valid_d;
      s1WetOk_q   <= s1WetOk_d;
      s1Enable_q  <= s1Enable_d;
      s1Dry_q     <= s1Dry_d;
      outValid_q  <= outValid_d;
      outSample_q <= outSample_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_sample = outSample_q;

endmodule

// File: tb/tb_flanger_delay_line.sv
// Randomized bench for flanger_delay_line against a sample-history reference model.
module tb_flanger_delay_line;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int MW   = 8;
  localparam int BD   = 4;
  localparam int MAXD = (1 << AW) - 2;

  logic                 CLK = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_sample;
  logic        [MW-1:0] mod_value;
  logic                 enable;
  logic                 out_valid;
  logic signed [DW-1:0] out_sample;

  flanger_delay_line #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MOD_WIDTH  (MW),
    .BASE_DELAY (BD)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .mod_value  (mod_value),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 CLK = ~CLK;

  int edgeCount = 0;
  always @(posedge CLK) edgeCount++;

  typedef struct {
    int due;
    int value;
  } exp_t;

  exp_t expQ[$];
  int   hist[$];
  int   lastOut     = 0;
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0d, want %0d", tag, $time, observed, expected);
    end
  endtask

  // Reference: the tap is simply the sample written d samples ago, or 0 if fewer exist.
  task automatic applyStimulus(input bit v, input int s, input int m, input bit en);
    int d;
    int n;
    int wet;
    in_valid  = v;
    in_sample = DW'(s);
    mod_value = MW'(m);
    enable    = en;
    if (v) begin
      d   = (BD + m > MAXD) ? MAXD : BD + m;
      n   = hist.size();
      wet = (n >= d) ? hist[n-d] : 0;
      hist.push_back(s);
      expQ.push_back('{edgeCount + 2, en ? ((s + wet) >>> 1) : s});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_sample", out_sample, 0);
    expQ.delete();
    hist.delete();
    lastOut = 0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b1;
  endtask

  function automatic int randSample();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return int'(r);
  endfunction

  always @(negedge CLK) begin
    if (expQ.size() > 0 && expQ[0].due == edgeCount) begin
      checkOutput("out_valid", {31'b0, out_valid}, 1);
      checkOutput("out_sample", out_sample, expQ[0].value);
      lastOut = expQ[0].value;
      void'(expQ.pop_front());
    end else begin
      checkOutput("idle_valid", {31'b0, out_valid}, 0);
      checkOutput("hold_sample", out_sample, lastOut);
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    mod_value = '0;
    enable    = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("init_valid", {31'b0, out_valid}, 0);
    checkOutput("init_sample", out_sample, 0);
    @(posedge CLK);
    #1;
    rst = 1'b1;
    @(posedge CLK);
    #1;

    // Impulse through the base delay
    applyStimulus(1, 1000, 0, 1);
    repeat (12) applyStimulus(1, 0, 0, 1);

    // Fill gating on a constant stream
    doReset();
    repeat (10) applyStimulus(1, 7, 0, 1);

    // Arithmetic extremes and floor rounding
    repeat (8) applyStimulus(1, 32767, 0, 1);
    repeat (8) applyStimulus(1, -32768, 0, 1);
    applyStimulus(1, -4, 0, 1);
    repeat (3) applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 3, 0, 1);

    // Bypass with gaps, then mixing with gaps
    repeat (60) applyStimulus($urandom_range(0, 2) != 0, randSample(), $urandom_range(0, 255), 0);
    repeat (60) applyStimulus($urandom_range(0, 2) != 0, randSample(), $urandom_range(0, 20), 1);

    // Clamped delay and pointer wrap
    doReset();
    applyStimulus(1, 1000, 255, 1);
    repeat (650) applyStimulus(1, 0, 255, 1);

    // Fully random traffic
    repeat (700) applyStimulus($urandom_range(0, 3) != 0, randSample(), $urandom_range(0, 255),
                               $urandom_range(0, 3) != 0);

    // Reset with the pipeline full, then refill
    repeat (5) applyStimulus(1, randSample(), 0, 1);
    doReset();
    repeat (12) applyStimulus(1, randSample(), 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
